// File: rtl/dribbler_drive_ctrl.sv
// ---------------------------------------------------------------------------
// dribbler_drive_ctrl
//
// Drives the dribbler motor H-bridge from the single-bit dribbler request
// produced by the kick/dribbler command-bit extractor.
//   - 2-flop synchroniser on the asynchronous request
//   - soft-start duty ramp (IDLE -> RAMP -> RUN)
//   - glitch-free PWM: duty is shadowed and only changes at the period start
//   - timed active brake after release (BRAKE)
//   - immediate coast shutdown when enable drops
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   dribble_req  dribbler request (asynchronous, synchronised here)
//   enable       global motor enable (synchronous to clk)
//   pwm_out      registered PWM gate to the H-bridge
//   brake_out    registered brake command, never high together with pwm_out
//   running      high while the FSM is in RUN
//   duty         currently commanded duty (before the shadow register)
// ---------------------------------------------------------------------------
module dribbler_drive_ctrl #(
  parameter int PWM_BITS      = 8,
  parameter int DUTY_MAX      = 200,
  parameter int DUTY_STEP     = 8,
  parameter int RAMP_STEP_CYC = 1024,
  parameter int BRAKE_CYC     = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dribble_req,
  input  logic                enable,
  output logic                pwm_out,
  output logic                brake_out,
  output logic                running,
  output logic [PWM_BITS-1:0] duty
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RAMP  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] BRAKE = 2'd3;

  // Duty parameters are unsigned and truncated to the PWM width.
  localparam logic [PWM_BITS-1:0] DUTY_MAX_W  = DUTY_MAX[PWM_BITS-1:0];
  localparam logic [PWM_BITS-1:0] DUTY_STEP_W = DUTY_STEP[PWM_BITS-1:0];
  localparam logic [PWM_BITS-1:0] DUTY_FIRST  =
    (DUTY_STEP_W < DUTY_MAX_W) ? DUTY_STEP_W : DUTY_MAX_W;

  // Counter period is 2^PWM_BITS-1 so that duty = all-ones is a constant high.
  localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  localparam int STEP_CNT_W  = (RAMP_STEP_CYC > 1) ? $clog2(RAMP_STEP_CYC) : 1;
  localparam int BRAKE_CNT_W = (BRAKE_CYC > 1) ? $clog2(BRAKE_CYC) : 1;
  localparam logic [STEP_CNT_W-1:0]  STEP_LOAD  = STEP_CNT_W'(RAMP_STEP_CYC - 1);
  localparam logic [BRAKE_CNT_W-1:0] BRAKE_LOAD = BRAKE_CNT_W'(BRAKE_CYC - 1);

  logic [1:0]             sync_q;
  logic                   req_s;
  logic [1:0]             state_q, state_d;
  logic [PWM_BITS-1:0]    duty_q, duty_d;
  logic [STEP_CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic [BRAKE_CNT_W-1:0] brake_cnt_q, brake_cnt_d;
  logic [PWM_BITS-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0]    shadow_q, shadow_d;
  logic                   pwm_q, pwm_d;
  logic                   brake_q, brake_d;
  logic                   shadow_clr;
  logic                   drive_en;
  logic [PWM_BITS:0]      duty_sum;
  logic [PWM_BITS-1:0]    duty_next;

  assign req_s = sync_q[1];

  // One extra bit so the increment can never wrap past DUTY_MAX.
  assign duty_sum  = {1'b0, duty_q} + {1'b0, DUTY_STEP_W};
  assign duty_next = (duty_sum > {1'b0, DUTY_MAX_W}) ? DUTY_MAX_W
                                                     : duty_sum[PWM_BITS-1:0];

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    duty_d      = duty_q;
    step_cnt_d  = step_cnt_q;
    brake_cnt_d = brake_cnt_q;
    shadow_clr  = 1'b0;

    if (!enable) begin
      // Coast: no brake, drive removed at the very next edge.
      state_d    = IDLE;
      duty_d     = '0;
      shadow_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          duty_d = '0;
          if (req_s) begin
            state_d    = RAMP;
            duty_d     = DUTY_FIRST;
            step_cnt_d = STEP_LOAD;
          end
        end
        RAMP, RUN: begin
          if (!req_s) begin
            state_d     = BRAKE;
            duty_d      = '0;
            brake_cnt_d = BRAKE_LOAD;
            shadow_clr  = 1'b1;
          end else if (state_q == RUN) begin
            duty_d = DUTY_MAX_W;
          end else if (step_cnt_q == '0) begin
            duty_d     = duty_next;
            step_cnt_d = STEP_LOAD;
            if (duty_next == DUTY_MAX_W) state_d = RUN;
          end else begin
            step_cnt_d = step_cnt_q - 1'b1;
          end
        end
        BRAKE: begin
          // Request is ignored here; the brake always runs to completion.
          duty_d = '0;
          if (brake_cnt_q == '0) state_d = IDLE;
          else brake_cnt_d = brake_cnt_q - 1'b1;
        end
        default: begin
          state_d = IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
    // Shadow only follows duty at the period start, except forced clears.
    if (shadow_clr)            shadow_d = '0;
    else if (pwm_cnt_q == '0)  shadow_d = duty_q;
    else                       shadow_d = shadow_q;
    // Both outputs are gated by the *next* state, so the edge that enters
    // BRAKE drops pwm and raises brake together with no overlap cycle.
    drive_en = (state_d == RAMP) || (state_d == RUN);
    pwm_d    = drive_en && (pwm_cnt_q < shadow_d);
    brake_d  = (state_d == BRAKE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      duty_q      <= '0;
      step_cnt_q  <= '0;
      brake_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      shadow_q    <= '0;
      pwm_q       <= 1'b0;
      brake_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], dribble_req};
      state_q     <= state_d;
      duty_q      <= duty_d;
      step_cnt_q  <= step_cnt_d;
      brake_cnt_q <= brake_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      shadow_q    <= shadow_d;
      pwm_q       <= pwm_d;
      brake_q     <= brake_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign brake_out = brake_q;
  assign running   = (state_q == RUN);
  assign duty      = duty_q;

endmodule
